// File: rtl/inverse_butterfly_unit.sv
// Pipelined radix-2 inverse butterfly: recovers a=(y1+y2)/2 and
// b=((y1-y2)/2)*conj(w) from a forward-butterfly output pair.
// Three register stages share a single advance enable driven by output back-pressure.
// A sticky flag records any lost significant bits in the wrapped outputs.
module inverse_butterfly_unit #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] y2,
  input  logic [WIDTH-1:0] twiddle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  input  logic             ovf_clr,
  output logic             ovf
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * H + 2;

  // Floor division of a product by 2**(FRAC+1): twiddle scale plus the /2.
  function automatic logic signed [PW-1:0] floor_shr(input logic signed [PW-1:0] v);
    return v >>> (FRAC + 1);
  endfunction

  // True when v survives truncation to H signed bits unchanged.
  function automatic logic fits_h(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] t;
    t = {{(PW-H){v[H-1]}}, v[H-1:0]};
    return t == v;
  endfunction

  logic adv;
  logic vld_p0, vld_p1, vld_p2;

  assign adv       = !vld_p2 || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;

  logic signed [H:0] y1_re, y1_im, y2_re, y2_im;

  assign y1_re = {y1[WIDTH-1], y1[WIDTH-1:H]};
  assign y1_im = {y1[H-1], y1[H-1:0]};
  assign y2_re = {y2[WIDTH-1], y2[WIDTH-1:H]};
  assign y2_im = {y2[H-1], y2[H-1:0]};

  // Valid bits march with the data; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- Stage 1: sum/difference, twiddle registered alongside ----
  logic signed [H:0]  s_re_p0, s_im_p0, d_re_p0, d_im_p0;
  logic [WIDTH-1:0]   w_p0;

  // Stage 1 data registers (no reset: qualified by vld_p0).
  always_ff @(posedge clk) begin
    if (adv) begin
      s_re_p0 <= y1_re + y2_re;
      s_im_p0 <= y1_im + y2_im;
      d_re_p0 <= y1_re - y2_re;
      d_im_p0 <= y1_im - y2_im;
      w_p0    <= twiddle;
    end
  end

  // ---- Stage 2: halve the sum, multiply difference by conj(w) ----
  logic signed [PW-1:0] d_re_x, d_im_x, w_re_x, w_im_x, p_re_c, p_im_c;

  assign d_re_x = {{(PW-H-1){d_re_p0[H]}}, d_re_p0};
  assign d_im_x = {{(PW-H-1){d_im_p0[H]}}, d_im_p0};
  assign w_re_x = {{(PW-H){w_p0[WIDTH-1]}}, w_p0[WIDTH-1:H]};
  assign w_im_x = {{(PW-H){w_p0[H-1]}}, w_p0[H-1:0]};
  assign p_re_c = d_re_x * w_re_x + d_im_x * w_im_x;
  assign p_im_c = d_im_x * w_re_x - d_re_x * w_im_x;

  logic signed [H:0]    a_re_p1, a_im_p1;
  logic signed [PW-1:0] p_re_p1, p_im_p1;

  // Stage 2 data registers (no reset: qualified by vld_p1).
  always_ff @(posedge clk) begin
    if (adv) begin
      a_re_p1 <= s_re_p0 >>> 1;
      a_im_p1 <= s_im_p0 >>> 1;
      p_re_p1 <= p_re_c;
      p_im_p1 <= p_im_c;
    end
  end

  // ---- Stage 3: rescale product, wrap to H bits, detect lost bits ----
  logic signed [PW-1:0] b_re_c, b_im_c, a_re_x, a_im_x;
  logic                 ovf_hit;

  assign b_re_c  = floor_shr(p_re_p1);
  assign b_im_c  = floor_shr(p_im_p1);
  assign a_re_x  = {{(PW-H-1){a_re_p1[H]}}, a_re_p1};
  assign a_im_x  = {{(PW-H-1){a_im_p1[H]}}, a_im_p1};
  assign ovf_hit = !fits_h(a_re_x) || !fits_h(a_im_x) ||
                   !fits_h(b_re_c) || !fits_h(b_im_c);

  // Output registers load only with valid data so they hold across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x1 <= '0;
      x2 <= '0;
    end else if (adv && vld_p1) begin
      x1 <= {a_re_p1[H-1:0], a_im_p1[H-1:0]};
      x2 <= {b_re_c[H-1:0], b_im_c[H-1:0]};
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (adv && vld_p1 && ovf_hit) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inverse_butterfly_unit.sv
// Directed testbench for inverse_butterfly_unit (WIDTH=16, FRAC=6).
module tb_inverse_butterfly_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y1, y2, twiddle;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x1, x2;
  logic        ovf_clr;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  inverse_butterfly_unit #(.WIDTH(16), .FRAC(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .y1(y1), .y2(y2), .twiddle(twiddle),
    .out_valid(out_valid), .out_ready(out_ready),
    .x1(x1), .x2(x2),
    .ovf_clr(ovf_clr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cx(input int re, input int im);
    return {re[7:0], im[7:0]};
  endfunction

  // Drive one pair, wait (bounded) for its result; no checking here.
  task automatic send_and_wait(input logic [15:0] a, input logic [15:0] b, input logic [15:0] w,
                               output int lat, output logic [15:0] r1, output logic [15:0] r2,
                               output logic rovf);
    y1 = a; y2 = b; twiddle = w;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    r1 = x1; r2 = x2; rovf = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    y1 = '0; y2 = '0; twiddle = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (x1 !== 16'h0) begin errors++; $display("FAIL reset_x1 got=%h exp=0000", x1); end
    checks++; if (x2 !== 16'h0) begin errors++; $display("FAIL reset_x2 got=%h exp=0000", x2); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [15:0] r1, r2; logic rv;
    // s=(16,2) d=(4,6); a=(8,1); p=(256,384) -> b=(2,3)
    send_and_wait(cx(10,4), cx(6,-2), cx(64,0), lat, r1, r2, rv);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    checks++; if (r1 !== cx(8,1)) begin errors++; $display("FAIL basic_x1 got=%h exp=%h", r1, cx(8,1)); end
    checks++; if (r2 !== cx(2,3)) begin errors++; $display("FAIL basic_x2 got=%h exp=%h", r2, cx(2,3)); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", rv); end
  endtask

  task automatic test_rotated_twiddle();
    int lat; logic [15:0] r1, r2; logic rv;
    // d=(6,-4), w=(0,-64): p_re=256, p_im=384 -> b=(2,3)
    send_and_wait(cx(11,-1), cx(5,3), cx(0,-64), lat, r1, r2, rv);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rot_latency got=%0d exp=3", lat); end
    checks++; if (r1 !== cx(8,1)) begin errors++; $display("FAIL rot_x1 got=%h exp=%h", r1, cx(8,1)); end
    checks++; if (r2 !== cx(2,3)) begin errors++; $display("FAIL rot_x2 got=%h exp=%h", r2, cx(2,3)); end
  endtask

  task automatic test_floor();
    int lat; logic [15:0] r1, r2; logic rv;
    // 3>>>1=1; 3*64=192, 192>>>7=1
    send_and_wait(cx(3,0), cx(0,0), cx(64,0), lat, r1, r2, rv);
    checks++; if (r1 !== cx(1,0)) begin errors++; $display("FAIL floor_x1 got=%h exp=%h", r1, cx(1,0)); end
    checks++; if (r2 !== cx(1,0)) begin errors++; $display("FAIL floor_x2 got=%h exp=%h", r2, cx(1,0)); end
    // negative floor: y1=(-3,0): a=-2, d=-3, -192>>>7=-2
    send_and_wait(cx(-3,0), cx(0,0), cx(64,0), lat, r1, r2, rv);
    checks++; if (r1 !== cx(-2,0)) begin errors++; $display("FAIL floor_neg_x1 got=%h exp=%h", r1, cx(-2,0)); end
    checks++; if (r2 !== cx(-2,0)) begin errors++; $display("FAIL floor_neg_x2 got=%h exp=%h", r2, cx(-2,0)); end
  endtask

  task automatic test_overflow();
    int lat; logic [15:0] r1, r2; logic rv;
    // s=(-1,0) d=(255,0) w=(127,127): p_re=32385 -> 253 -> wraps to -3;
    // p_im=-32385 -> floor -254 -> wraps to 2
    send_and_wait(cx(127,0), cx(-128,0), cx(127,127), lat, r1, r2, rv);
    checks++; if (r1 !== cx(-1,0)) begin errors++; $display("FAIL ovf_x1 got=%h exp=%h", r1, cx(-1,0)); end
    checks++; if (r2 !== cx(-3,2)) begin errors++; $display("FAIL ovf_x2 got=%h exp=%h", r2, cx(-3,2)); end
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", rv); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    // clear held high while a new overflow lands: set wins on that edge
    ovf_clr = 1'b1;
    send_and_wait(cx(127,0), cx(-128,0), cx(127,127), lat, r1, r2, rv);
    ovf_clr = 1'b0;
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", rv); end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got=%b exp=0", ovf); end
  endtask

  task automatic test_back_to_back_stall();
    logic [15:0] ex1 [5];
    logic [15:0] ex2 [5];
    int sent, got;
    // y1=(4i+4,2) y2=(2,0) w=1.0 -> a=(2i+3,1), b=(2i+1,1)
    for (int i = 0; i < 5; i++) begin
      ex1[i] = cx(2*i+3, 1);
      ex2[i] = cx(2*i+1, 1);
    end
    sent = 0; got = 0;
    twiddle = cx(64,0);
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      out_ready = (cyc >= 8);
      in_valid  = (sent < 5);
      y1 = cx(4*sent+4, 2);
      y2 = cx(2, 0);
      #1;
      if (cyc >= 4 && cyc < 8) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
        checks++; if (x1 !== ex1[0]) begin errors++; $display("FAIL stall_x1_hold cyc=%0d got=%h exp=%h", cyc, x1, ex1[0]); end
        checks++; if (x2 !== ex2[0]) begin errors++; $display("FAIL stall_x2_hold cyc=%0d got=%h exp=%h", cyc, x2, ex2[0]); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (x1 !== ex1[got] || x2 !== ex2[got]) begin
          errors++;
          $display("FAIL stream_out%0d got=%h/%h exp=%h/%h", got, x1, x2, ex1[got], ex2[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (got !== 5) begin errors++; $display("FAIL stream_count got=%0d exp=5", got); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_no_dup out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    int lat; logic [15:0] r1, r2; logic rv;
    int seen;
    send_and_wait(cx(127,0), cx(-128,0), cx(127,127), lat, r1, r2, rv);
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL mid_pre_ovf got=%b exp=1", rv); end
    out_ready = 1'b1; twiddle = cx(64,0);
    for (int i = 0; i < 3; i++) begin
      y1 = cx(20+i, 0); y2 = cx(0, 0); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (x1 !== 16'h0) begin errors++; $display("FAIL mid_x1 got=%h exp=0000", x1); end
    checks++; if (x2 !== 16'h0) begin errors++; $display("FAIL mid_x2 got=%h exp=0000", x2); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_flushed stale_outputs=%0d exp=0", seen); end
    send_and_wait(cx(10,4), cx(6,-2), cx(64,0), lat, r1, r2, rv);
    checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_latency got=%0d exp=3", lat); end
    checks++; if (r1 !== cx(8,1) || r2 !== cx(2,3)) begin
      errors++; $display("FAIL post_reset_data got=%h/%h exp=%h/%h", r1, r2, cx(8,1), cx(2,3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotated_twiddle();
    test_floor();
    test_overflow();
    test_back_to_back_stall();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
